// File: rtl/fpu_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_result_writer
// Purpose  : Collects 64-bit FPU results from a valid/ready stream, buffers
//            them in a small FIFO and writes them to a result memory at
//            sequential addresses starting from BASE_ADDR. A run is started
//            by a one-cycle start pulse, the in_last beat moves the block to
//            DRAIN, and DONE is reached once the buffer has been emptied.
//
// Ports    : clk        - clock, all logic on posedge
//            reset      - synchronous, active-low reset
//            start      - one-cycle pulse, begins a run (IDLE/DONE only)
//            in_valid   - result on in_result is valid
//            in_ready   - block can accept a result this cycle
//            in_result  - FPU result word
//            in_last    - final result of the run (qualifies in_valid)
//            mem_we     - write request to result memory
//            mem_addr   - write address
//            mem_wdata  - write data (FIFO head)
//            mem_ready  - memory accepts the write this cycle
//            busy       - high in RUN or DRAIN
//            done       - high in DONE until the next start
//            wr_count   - results written in the current run (saturating)
//            wrapped    - sticky: write address wrapped past 2^ADDR_W-1
//            nan_count  - NaN results written (saturating at 255)
//
// Options  : FPU_WR_NAN_COUNT_EN - when defined, completed writes of NaN
//            words (exponent all ones, fraction non-zero) are counted on
//            nan_count; otherwise nan_count is tied to zero.
//
// Revision : 1.0 - initial release
// ============================================================================
module fpu_result_writer #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic              wrapped,
    output logic [7:0]        nan_count
);

    localparam int              c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0] c_depth    = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] c_base    = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;

    logic [DATA_W-1:0]    fifo_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   wr_ptr_q, rd_ptr_q;
    logic [c_ptr_w:0]     count_q, count_d;

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W:0]      wr_count_q, wr_count_d;
    logic                 wrapped_q, wrapped_d;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_clear;
    logic [DATA_W-1:0]    w_head;

    // ------------------------------------------------------------------
    // Handshakes. in_ready looks only at registered state/count, so a full
    // FIFO cannot accept in the same cycle a pop frees a slot. mem_we is
    // also gated by reset so nothing is written in the reset cycle itself.
    // ------------------------------------------------------------------
    assign w_head    = fifo_q[rd_ptr_q];
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign in_ready  = (state_q == S_RUN) && (count_q < c_depth);
    assign mem_we    = reset && busy && (count_q != '0);
    assign mem_addr  = addr_q;
    assign mem_wdata = w_head;
    assign wr_count  = wr_count_q;
    assign wrapped   = wrapped_q;

    assign w_push    = in_valid && in_ready;
    assign w_pop     = mem_we && mem_ready;

    // ------------------------------------------------------------------
    // Run-control FSM: next state and run-clear strobe
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        w_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    w_clear = 1'b1;
                end
            end
            S_RUN: begin
                if (w_push && in_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // No pushes here, so an empty FIFO means no write pending.
                if (count_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    w_clear = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Occupancy and write-side bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        addr_d     = addr_q;
        wr_count_d = wr_count_q;
        wrapped_d  = wrapped_q;
        if (w_clear) begin
            addr_d     = c_base;
            wr_count_d = '0;
            wrapped_d  = 1'b0;
        end else if (w_pop) begin
            // addr_q + 1 rolls over to zero naturally at the top address.
            addr_d = addr_q + 1'b1;
            if (addr_q == '1) begin
                wrapped_d = 1'b1;
            end
            if (wr_count_q != '1) begin
                wr_count_d = wr_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= c_base;
            wr_count_q <= '0;
            wrapped_q  <= 1'b0;
            // Clearing storage keeps mem_wdata at zero out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            wr_count_q <= wr_count_d;
            wrapped_q  <= wrapped_d;
            if (w_push) begin
                fifo_q[wr_ptr_q] <= in_result;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional NaN counter
    // ------------------------------------------------------------------
`ifdef FPU_WR_NAN_COUNT_EN
    logic [7:0] nan_q, nan_d;
    logic       w_is_nan;

    assign w_is_nan  = (&w_head[62:52]) && (|w_head[51:0]);
    assign nan_count = nan_q;

    always_comb begin
        nan_d = nan_q;
        if (w_clear) begin
            nan_d = '0;
        end else if (w_pop && w_is_nan && (nan_q != 8'hFF)) begin
            nan_d = nan_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            nan_q <= '0;
        end else begin
            nan_q <= nan_d;
        end
    end
`else
    assign nan_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_result_writer
// Purpose  : Directed self-checking bench for fpu_result_writer. Two DUTs
//            share all inputs: u_dut (BASE_ADDR=0) and u_dut_hi
//            (BASE_ADDR=8190) for the address-wrap scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_result_writer;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 13;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_result;
    logic              in_last;
    logic              mem_ready;

    logic              in_ready,  in_ready2;
    logic              mem_we,    mem_we2;
    logic [ADDR_W-1:0] mem_addr,  mem_addr2;
    logic [DATA_W-1:0] mem_wdata, mem_wdata2;
    logic              busy,      busy2;
    logic              done,      done2;
    logic [ADDR_W:0]   wr_count,  wr_count2;
    logic              wrapped,   wrapped2;
    logic [7:0]        nan_count, nan_count2;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t q1[$];
    wr_t q2[$];

    fpu_result_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .BASE_ADDR(0)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .wr_count(wr_count), .wrapped(wrapped), .nan_count(nan_count)
    );

    fpu_result_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .BASE_ADDR(8190)) u_dut_hi (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready2), .in_result(in_result), .in_last(in_last),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ready(mem_ready),
        .busy(busy2), .done(done2), .wr_count(wr_count2), .wrapped(wrapped2), .nan_count(nan_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed memory write of both DUTs.
    always @(posedge clk) begin
        if (mem_we && mem_ready)   q1.push_back('{a: mem_addr,  d: mem_wdata});
        if (mem_we2 && mem_ready)  q2.push_back('{a: mem_addr2, d: mem_wdata2});
    end

    // ---------------------------------------------------------------- helpers
    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [DATA_W-1:0] data, input logic last);
        int n = 0;
        in_valid  = 1'b1;
        in_result = data;
        in_last   = last;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (!in_ready) $display("FAIL send_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(done && done2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (!(done && done2)) $display("FAIL wait_done: done=%b done2=%b after %0d cycles, required 1", done, done2, n);
        else n_pass++;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b, required 0", in_ready); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b, required 0", mem_we); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b, required 0", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
        n_total++; if (mem_addr !== 13'd0) $display("FAIL rst_mem_addr: got %0d, required 0", mem_addr); else n_pass++;
        n_total++; if (mem_addr2 !== 13'd8190) $display("FAIL rst_mem_addr_hi: got %0d, required 8190", mem_addr2); else n_pass++;
        n_total++; if (mem_wdata !== 64'd0) $display("FAIL rst_mem_wdata: got %h, required 0", mem_wdata); else n_pass++;
        n_total++; if (wr_count !== 14'd0) $display("FAIL rst_wr_count: got %0d, required 0", wr_count); else n_pass++;
        n_total++; if (wrapped !== 1'b0) $display("FAIL rst_wrapped: got %b, required 0", wrapped); else n_pass++;
        n_total++; if (nan_count !== 8'd0) $display("FAIL rst_nan_count: got %0d, required 0", nan_count); else n_pass++;
    endtask

    task automatic test_basic_run();
        logic [DATA_W-1:0] exp_d [3];
        exp_d[0] = 64'h3FF0000000000000;
        exp_d[1] = 64'h4000000000000000;
        exp_d[2] = 64'h4008000000000000;
        mem_ready = 1'b1;
        q1.delete(); q2.delete();
        start_pulse();
        n_total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b, required 1", busy); else n_pass++;
        send(exp_d[0], 1'b0);
        // First accepted result must be on mem_we the very next cycle.
        n_total++; if (mem_we !== 1'b1) $display("FAIL basic_latency_we: got %b, required 1", mem_we); else n_pass++;
        send(exp_d[1], 1'b0);
        send(exp_d[2], 1'b1);
        wait_done();
        n_total++; if (q1.size() != 3) $display("FAIL basic_nwrites: got %0d, required 3", q1.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i < q1.size()) begin
                n_total++; if (q1[i].a !== 13'(i)) $display("FAIL basic_addr%0d: got %0d, required %0d", i, q1[i].a, i); else n_pass++;
                n_total++; if (q1[i].d !== exp_d[i]) $display("FAIL basic_data%0d: got %h, required %h", i, q1[i].d, exp_d[i]); else n_pass++;
            end
        end
        n_total++; if (wr_count !== 14'd3) $display("FAIL basic_wr_count: got %0d, required 3", wr_count); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b, required 0", busy); else n_pass++;
        n_total++; if (wrapped !== 1'b0) $display("FAIL basic_wrapped: got %b, required 0", wrapped); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] exp_d [5];
        for (int i = 0; i < 5; i++) exp_d[i] = 64'hC000_0000_0000_0000 + 64'(i + 1);
        mem_ready = 1'b0;
        q1.delete(); q2.delete();
        start_pulse();
        for (int i = 0; i < 4; i++) send(exp_d[i], 1'b0);
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b, required 0", in_ready); else n_pass++;
        n_total++; if (mem_we !== 1'b1) $display("FAIL bp_mem_we: got %b, required 1", mem_we); else n_pass++;
        in_valid  = 1'b1;
        in_result = exp_d[4];
        in_last   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_total++; if (mem_addr !== 13'd0) $display("FAIL bp_hold_addr%0d: got %0d, required 0", k, mem_addr); else n_pass++;
            n_total++; if (mem_wdata !== exp_d[0]) $display("FAIL bp_hold_data%0d: got %h, required %h", k, mem_wdata, exp_d[0]); else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL bp_hold_ready%0d: got %b, required 0", k, in_ready); else n_pass++;
            @(negedge clk);
        end
        mem_ready = 1'b1;
        send(exp_d[4], 1'b1);
        wait_done();
        n_total++; if (q1.size() != 5) $display("FAIL bp_nwrites: got %0d, required 5", q1.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i < q1.size()) begin
                n_total++; if (q1[i].a !== 13'(i)) $display("FAIL bp_addr%0d: got %0d, required %0d", i, q1[i].a, i); else n_pass++;
                n_total++; if (q1[i].d !== exp_d[i]) $display("FAIL bp_data%0d: got %h, required %h", i, q1[i].d, exp_d[i]); else n_pass++;
            end
        end
        n_total++; if (wr_count !== 14'd5) $display("FAIL bp_wr_count: got %0d, required 5", wr_count); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_a [4];
        exp_a[0] = 13'd8190; exp_a[1] = 13'd8191; exp_a[2] = 13'd0; exp_a[3] = 13'd1;
        mem_ready = 1'b1;
        q1.delete(); q2.delete();
        start_pulse();
        n_total++; if (wrapped2 !== 1'b0) $display("FAIL wrap_cleared: got %b, required 0", wrapped2); else n_pass++;
        n_total++; if (mem_addr2 !== 13'd8190) $display("FAIL wrap_base: got %0d, required 8190", mem_addr2); else n_pass++;
        for (int i = 0; i < 4; i++) send(64'h4010_0000_0000_0000 + 64'(i), (i == 3));
        wait_done();
        n_total++; if (q2.size() != 4) $display("FAIL wrap_nwrites: got %0d, required 4", q2.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (i < q2.size()) begin
                n_total++; if (q2[i].a !== exp_a[i]) $display("FAIL wrap_addr%0d: got %0d, required %0d", i, q2[i].a, exp_a[i]); else n_pass++;
            end
        end
        n_total++; if (wrapped2 !== 1'b1) $display("FAIL wrap_flag: got %b, required 1", wrapped2); else n_pass++;
        n_total++; if (wrapped !== 1'b0) $display("FAIL wrap_flag_lo: got %b, required 0", wrapped); else n_pass++;
        n_total++; if (wr_count2 !== 14'd4) $display("FAIL wrap_wr_count: got %0d, required 4", wr_count2); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        mem_ready = 1'b0;
        q1.delete(); q2.delete();
        start_pulse();
        send(64'h1111_1111_1111_1111, 1'b0);
        send(64'h2222_2222_2222_2222, 1'b0);
        n_total++; if (mem_we !== 1'b1) $display("FAIL mid_we_before: got %b, required 1", mem_we); else n_pass++;
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_total++; if (mem_we !== 1'b0) $display("FAIL mid_we_in_reset: got %b, required 0", mem_we); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++; if (q1.size() != 0) $display("FAIL mid_no_write: got %0d writes, required 0", q1.size()); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL mid_we_after: got %b, required 0", mem_we); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b, required 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL mid_done: got %b, required 0", done); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready: got %b, required 0", in_ready); else n_pass++;
        @(negedge clk);
        start_pulse();
        // FIFO must be empty: nothing to write right after the new start.
        n_total++; if (mem_we !== 1'b0) $display("FAIL mid_fifo_empty: got mem_we=%b, required 0", mem_we); else n_pass++;
        send(64'h3333_3333_3333_3333, 1'b1);
        wait_done();
        n_total++; if (q1.size() != 1) $display("FAIL mid_nwrites: got %0d, required 1", q1.size()); else n_pass++;
        if (q1.size() > 0) begin
            n_total++; if (q1[0].a !== 13'd0) $display("FAIL mid_addr: got %0d, required 0", q1[0].a); else n_pass++;
            n_total++; if (q1[0].d !== 64'h3333_3333_3333_3333) $display("FAIL mid_data: got %h, required 3333333333333333", q1[0].d); else n_pass++;
        end
    endtask

    task automatic test_nan_count();
        logic [7:0] exp_nan;
`ifdef FPU_WR_NAN_COUNT_EN
        exp_nan = 8'd2;
`else
        exp_nan = 8'd0;
`endif
        mem_ready = 1'b1;
        q1.delete(); q2.delete();
        start_pulse();
        n_total++; if (nan_count !== 8'd0) $display("FAIL nan_cleared: got %0d, required 0", nan_count); else n_pass++;
        send(64'h7FF8000000000000, 1'b0);
        send(64'h7FF0000000000000, 1'b0);
        send(64'hFFFFFFFFFFFFFFFF, 1'b1);
        wait_done();
        n_total++; if (nan_count !== exp_nan) $display("FAIL nan_count: got %0d, required %0d", nan_count, exp_nan); else n_pass++;
        n_total++; if (wr_count !== 14'd3) $display("FAIL nan_wr_count: got %0d, required 3", wr_count); else n_pass++;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_last   = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_run();
        test_backpressure();
        test_wrap();
        test_reset_mid_run();
        test_nan_count();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
